// File: rtl/neuron_pkg.sv
// Shared definitions for the fixed-point neuron datapath.
//   DATA_WIDTH / FRAC_BITS : default word format (Q7.24 in 32 bits)
//   q7_24_t                : signed Q7.24 word
//   Q_ONE / Q_MAX          : 1.0 and the largest positive Q7.24 value
//   sat_relu()             : clamps a wide signed sum into [0, Q_MAX]
package neuron_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 24;

  typedef logic signed [31:0] q7_24_t;

  localparam q7_24_t Q_ONE = 32'sd16777216;
  localparam q7_24_t Q_MAX = 32'sh7FFF_FFFF;

  // Width of the sum accepted by sat_relu; callers sign-extend into it.
  localparam int SAT_IN_W = 128;

  // ReLU with positive saturation: negative or zero sums give 0, sums
  // above Q_MAX clamp to Q_MAX, everything else passes the low word.
  function automatic q7_24_t sat_relu(input logic signed [SAT_IN_W-1:0] s);
    logic signed [SAT_IN_W-1:0] max_wide;
    max_wide = $signed({{(SAT_IN_W-32){1'b0}}, Q_MAX});
    if (s[SAT_IN_W-1] || (s == '0)) begin
      return '0;
    end else if (s > max_wide) begin
      return Q_MAX;
    end else begin
      return s[31:0];
    end
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// Combinational signed fixed-point multiply.
//   a, b : signed DATA_WIDTH operands in the same Q format
//   p    : full 2*DATA_WIDTH product shifted right by FRAC_BITS
//          (arithmetic shift, so it truncates toward minus infinity)
module fixed_mul
  #(parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 24)
  (input  logic signed [DATA_WIDTH-1:0]   a,
   input  logic signed [DATA_WIDTH-1:0]   b,
   output logic signed [2*DATA_WIDTH-1:0] p);

  import neuron_pkg::*;

  logic signed [2*DATA_WIDTH-1:0] full;

  // Both operands are signed, so they are sign-extended to the product
  // width before multiplying; the full product always fits.
  assign full = a * b;
  assign p    = full >>> FRAC_BITS;

endmodule

// File: rtl/relu_neuron.sv
// Fully pipelined neuron: data_output = max(0, sum(d[i]*w[i]) + bias),
// saturated to the largest positive word. Two-cycle latency, one vector
// per clock.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : data_inputs/weights/bias hold a vector this cycle
//   data_inputs  : activations from the previous layer
//   weights      : per-input weights
//   bias         : neuron bias
//   out_valid    : data_output carries a new result this cycle
//   data_output  : ReLU result, always >= 0; holds when out_valid is 0
//
// Flow control: valid-only. A vector is taken on every rising edge where
// in_valid=1 and rst=0; there is no ready, so the source never stalls and
// the sink must accept a result on every cycle out_valid=1. Each accepted
// vector produces exactly one out_valid pulse two edges later.
module relu_neuron
  #(parameter int PREV_LAYER_OUTPUTS = 3,
    parameter int DATA_WIDTH         = 32,
    parameter int FRAC_BITS          = 24)
  (input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] data_inputs [0:PREV_LAYER_OUTPUTS-1],
   input  logic signed [DATA_WIDTH-1:0] weights     [0:PREV_LAYER_OUTPUTS-1],
   input  logic signed [DATA_WIDTH-1:0] bias,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] data_output);

  import neuron_pkg::*;

  localparam int PW    = 2 * DATA_WIDTH;
  // Room for every shifted product plus the bias without wrapping.
  localparam int ACC_W = PW + $clog2(PREV_LAYER_OUTPUTS + 1);

  // ---------------------------------------------------------------- mults
  logic signed [PW-1:0] prod [0:PREV_LAYER_OUTPUTS-1];

  for (genvar g = 0; g < PREV_LAYER_OUTPUTS; g++) begin : g_mul
    fixed_mul #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul (
      .a (data_inputs[g]),
      .b (weights[g]),
      .p (prod[g])
    );
  end

  // -------------------------------------------------------------- stage 1
  logic signed [PW-1:0]         p_q [0:PREV_LAYER_OUTPUTS-1];
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic                         v1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      bias_q <= '0;
      for (int i = 0; i < PREV_LAYER_OUTPUTS; i++) begin
        p_q[i] <= '0;
      end
    end else begin
      v1_q <= in_valid;
      // Data registers only load on a valid vector.
      if (in_valid) begin
        bias_q <= bias;
        for (int i = 0; i < PREV_LAYER_OUTPUTS; i++) begin
          p_q[i] <= prod[i];
        end
      end
    end
  end

  // ------------------------------------------------------------ adder tree
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    sum = {{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    for (int i = 0; i < PREV_LAYER_OUTPUTS; i++) begin
      sum = sum + {{(ACC_W-PW){p_q[i][PW-1]}}, p_q[i]};
    end
  end

  // ------------------------------------------------------------ activation
  logic signed [DATA_WIDTH-1:0] act;

  if (DATA_WIDTH == 32 && ACC_W < SAT_IN_W) begin : g_act_pkg
    // Default word format: reuse the shared clamp.
    assign act = sat_relu({{(SAT_IN_W-ACC_W){sum[ACC_W-1]}}, sum});
  end else begin : g_act_gen
    localparam logic signed [ACC_W-1:0] OUT_MAX =
      $signed({{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});

    always_comb begin
      if (sum[ACC_W-1] || (sum == '0)) begin
        act = '0;
      end else if (sum > OUT_MAX) begin
        act = OUT_MAX[DATA_WIDTH-1:0];
      end else begin
        act = sum[DATA_WIDTH-1:0];
      end
    end
  end

  // -------------------------------------------------------------- stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      data_output <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        data_output <= act;
      end
    end
  end

endmodule

// File: tb/tb_relu_neuron.sv
// Directed bench for relu_neuron (three inputs, Q7.24).
module tb_relu_neuron;

  import neuron_pkg::*;

  localparam int N = 3;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // ------------------------------------------------------------------ dut
  logic               in_valid;
  logic signed [31:0] d [0:N-1];
  logic signed [31:0] w [0:N-1];
  logic signed [31:0] b;
  logic               out_valid;
  logic signed [31:0] data_output;

  relu_neuron #(.PREV_LAYER_OUTPUTS(N), .DATA_WIDTH(32), .FRAC_BITS(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .data_inputs (d),
    .weights     (w),
    .bias        (b),
    .out_valid   (out_valid),
    .data_output (data_output)
  );

  // ------------------------------------------------------------ bookkeeping
  int errors   = 0;
  int checks   = 0;
  int sent     = 0;
  int received = 0;
  int run      = 0;
  int max_run  = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Called just after a falling edge; applies one vector for one rising
  // edge and returns at the following falling edge.
  task automatic drive(input logic signed [31:0] d0, d1, d2,
                       input logic signed [31:0] w0, w1, w2,
                       input logic signed [31:0] bv,
                       input bit                 push,
                       input logic [31:0]        exp);
    d[0] = d0; d[1] = d1; d[2] = d2;
    w[0] = w0; w[1] = w1; w[2] = w2;
    b = bv;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ------------------------------------------------------------ scoreboard
  always @(negedge clk) begin
    if (out_valid === 1'b1 && rst === 1'b0) begin
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("data_output", data_output, exp_q.pop_front());
        received++;
      end
    end else begin
      run = 0;
    end
  end

  // --------------------------------------------------------------- stimulus
  localparam logic signed [31:0] HALF    = 32'sd8388608;
  localparam logic signed [31:0] QUARTER = 32'sd4194304;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;          // ignored while in reset
    d[0] = Q_ONE; d[1] = HALF; d[2] = QUARTER;
    w[0] = HALF;  w[1] = HALF; w[2] = HALF;
    b = '0;

    // Reset state, with in_valid held high throughout.
    idle(3);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data_output", data_output, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(2);
    check("reset_no_leak", 32'(out_valid), 32'd0);

    // Basic: 0.5 + 0.25 + 0.125 = 0.875, with latency checked per cycle.
    drive(Q_ONE, HALF, QUARTER, HALF, HALF, HALF, 32'sd0, 1'b1, 32'd14680064);
    check("basic_lat_edge1", 32'(out_valid), 32'd0);
    idle(1);
    check("basic_lat_edge2", 32'(out_valid), 32'd1);
    idle(1);
    check("basic_valid_drop", 32'(out_valid), 32'd0);
    check("basic_hold", data_output, 32'd14680064);

    // Negative clamp: 0.875 - 1.0 = -0.125.
    drive(Q_ONE, HALF, QUARTER, HALF, HALF, HALF, -32'sd16777216, 1'b1, 32'd0);
    idle(3);

    // Saturation: huge positive products and bias.
    drive(Q_MAX, Q_MAX, Q_MAX, Q_MAX, Q_MAX, Q_MAX, Q_MAX, 1'b1, 32'h7FFF_FFFF);
    idle(3);

    // Truncation toward minus infinity: -1 LSB * 1.0 = -1.
    drive(-32'sd1, 32'sd0, 32'sd0, Q_ONE, 32'sd0, 32'sd0, 32'sd1, 1'b1, 32'd0);
    idle(3);
    drive(-32'sd1, 32'sd0, 32'sd0, Q_ONE, 32'sd0, 32'sd0, 32'sd2, 1'b1, 32'd1);
    idle(3);

    // Streaming: five back-to-back vectors.
    max_run = 0;
    // 1.0*1.0 = 1.0
    drive(Q_ONE, Q_ONE, Q_ONE, Q_ONE, 32'sd0, 32'sd0, 32'sd0, 1'b1, 32'd16777216);
    // 3 LSB * 0.5 = 1.5 LSB -> 1
    drive(32'sd3, 32'sd0, 32'sd0, HALF, 32'sd0, 32'sd0, 32'sd0, 1'b1, 32'd1);
    // -3 LSB * 0.5 = -1.5 LSB -> -2, plus 5 -> 3
    drive(-32'sd3, 32'sd0, 32'sd0, HALF, 32'sd0, 32'sd0, 32'sd5, 1'b1, 32'd3);
    // 2.0 - 1.0 + 1.0 = 2.0
    drive(32'sd33554432, -32'sd16777216, Q_ONE, Q_ONE, Q_ONE, Q_ONE, 32'sd0,
          1'b1, 32'd33554432);
    // Q_MAX + 1 LSB must saturate, not wrap negative.
    drive(32'sd1, 32'sd0, 32'sd0, Q_ONE, 32'sd0, 32'sd0, Q_MAX, 1'b1, 32'h7FFF_FFFF);
    idle(4);
    check("stream_back_to_back", 32'(max_run), 32'd5);

    // Reset with two vectors in flight: one in stage 1, one presented
    // together with rst. Neither may produce a result.
    drive(Q_ONE, 32'sd0, 32'sd0, Q_ONE, 32'sd0, 32'sd0, 32'sd0, 1'b0, 32'd0);
    d[0] = HALF; w[0] = Q_ONE; b = '0;
    in_valid = 1'b1;
    rst      = 1'b1;
    idle(1);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_data_output", data_output, 32'd0);
    idle(1);
    check("midrst_drop1", 32'(out_valid), 32'd0);
    idle(1);
    check("midrst_drop2", 32'(out_valid), 32'd0);

    // Recovery: latency 2 after reset. 0.25*1.0 + 0.5*0.5 = 0.5
    drive(QUARTER, HALF, 32'sd0, Q_ONE, HALF, 32'sd0, 32'sd0, 1'b1, 32'd8388608);
    check("post_rst_edge1", 32'(out_valid), 32'd0);
    idle(1);
    check("post_rst_edge2", 32'(out_valid), 32'd1);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(received), 32'(sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/relu_neuron.md
# relu_neuron

Single fully-connected neuron with ReLU activation for the inference datapath: computes max(0, Σ dᵢ·wᵢ + bias) over `PREV_LAYER_OUTPUTS` signed Q7.24 inputs. One instance is placed per neuron in a hidden layer. It is fully pipelined: it accepts one input vector per clock and returns the activation two cycles later.

## Interface
Parameters:
- `PREV_LAYER_OUTPUTS`, default 3: number of inputs and weights (fan-in); must be ≥1.
- `DATA_WIDTH`, default 32: word width of all data, weights, bias and output.
- `FRAC_BITS`, default 24: fractional bits (Q7.24 by default).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the current input set is valid this cycle.
- `data_inputs` in signed [DATA_WIDTH-1:0] [0:PREV_LAYER_OUTPUTS-1]: activations from the previous layer.
- `weights` in signed [DATA_WIDTH-1:0] [0:PREV_LAYER_OUTPUTS-1]: per-input weights.
- `bias` in signed [DATA_WIDTH-1:0]: neuron bias.
- `out_valid` out 1: `data_output` holds a new result.
- `data_output` out signed [DATA_WIDTH-1:0]: ReLU result in Q7.24, always ≥0.

## Operation
- Product: pᵢ = (dᵢ × wᵢ) as a full 2·DATA_WIDTH signed product, then arithmetic right-shift by FRAC_BITS. This truncates toward −∞; there is no rounding.
- Sum: S = Σ pᵢ + bias.
  - Accumulator is 2·DATA_WIDTH + clog2(PREV_LAYER_OUTPUTS+1) bits, signed.
  - Bias is sign-extended into the accumulator.
  - The sum never wraps internally.
- Activation:
  - S ≤ 0 → output 0.
  - S > 2^(DATA_WIDTH-1)−1 → saturate to 0x7FFF_FFFF.
  - Otherwise → S[DATA_WIDTH-1:0].
- The block does not check for NaN or invalid encodings; every bit pattern is a valid two's-complement number.
- No backpressure. A new vector may be applied every cycle, and each result appears exactly once.
- Input values are sampled only when `in_valid`=1. When `in_valid`=0 the pipeline still advances and `out_valid` drops correspondingly.

## Timing
- Stage 1 (edge after input): register all shifted products pᵢ, the bias, and the valid bit.
- Stage 2 (next edge): register the adder-tree sum, ReLU and saturation into `data_output`/`out_valid`.
- Latency: inputs with `in_valid`=1 at edge N appear with `out_valid`=1 after edge N+2. Throughput is 1 per cycle.
- When `out_valid`=0, `data_output` holds its last value; it is not cleared.
- Reset:
  - All valid bits, `out_valid` and `data_output` become 0 on the first edge with `rst`=1.
  - Data pipeline registers also clear to 0.
  - In-flight vectors are discarded when reset is asserted mid-operation.
  - `in_valid` during reset is ignored.
- Simultaneous `rst` and `in_valid`: reset wins, and the vector is dropped.
- Back-to-back vectors on consecutive cycles produce results on consecutive cycles with no bubbles.

## Structure
- Shared package `neuron_pkg` contains:
  - `DATA_WIDTH`, `FRAC_BITS`
  - typedef `q7_24_t` (logic signed [31:0])
  - constants `Q_ONE` = 32'sd16777216 and `Q_MAX` = 32'sh7FFF_FFFF
  - function `sat_relu` (wide signed → q7_24_t clamp)
- Sub-module `fixed_mul`: a combinational signed DATA_WIDTH×DATA_WIDTH multiply with `>>> FRAC_BITS`, instantiated PREV_LAYER_OUTPUTS times via generate.
- The adder tree and activation are inline in `relu_neuron`.

## Test plan
- Basic (N=3): d = {16777216, 8388608, 4194304} (1.0, 0.5, 0.25), w = all 8388608 (0.5), bias 0, `in_valid` pulse → after 2 cycles `out_valid`=1 and output = 14680064 (0.875) exactly.
- Negative clamp: same d/w, bias = −16777216 (−1.0) → output 0 (S = −0.125).
- Saturation: d = w = 0x7FFF_FFFF for all three inputs, bias 0x7FFF_FFFF → output 0x7FFF_FFFF.
- Negative products and truncation: d0 = −1 LSB (−1), w0 = 16777216, others 0, bias 1 → p0 = −1, S = 0 → output 0. A second vector with bias 2 → output 1.
- Streaming: 5 distinct vectors on consecutive cycles → 5 consecutive `out_valid` cycles, each result matching a reference model, in order.
- Reset: assert `rst` for 1 cycle while 2 vectors are in flight → no `out_valid` for those vectors, and `data_output` = 0 after the reset edge. A subsequent vector completes with latency 2.
